// File: rtl/ntr_cmd_capture_if.sv
// ============================================================================
// ntr_cmd_capture_if : card-bus byte stream and command hand-off signals
// Revision 1.0
// ============================================================================
`default_nettype none

interface ntr_cmd_capture_if #(
  parameter int CMD_BYTES = 8,
  parameter int DCW       = 16
);
  localparam int BCW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

  logic                   cs1;
  logic [7:0]             data;
  logic [8*CMD_BYTES-1:0] cmd;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [BCW-1:0]         byte_cnt;
  logic [DCW-1:0]         data_cnt;
  logic                   abort;
  logic                   overrun;

  // master: bus host plus command consumer; slave: the capture block
  modport master (
    output cs1, data, cmd_ready,
    input  cmd, cmd_valid, byte_cnt, data_cnt, abort, overrun
  );

  modport slave (
    input  cs1, data, cmd_ready,
    output cmd, cmd_valid, byte_cnt, data_cnt, abort, overrun
  );
endinterface

`default_nettype wire

// File: rtl/ntr_cmd_capture.sv
// ============================================================================
// ntr_cmd_capture : captures the command bytes of each card-select frame
// Revision 1.0
// ============================================================================
`default_nettype none

module ntr_cmd_capture #(
  parameter int CMD_BYTES = 8,
  parameter int MSB_FIRST = 0,
  parameter int DCW       = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ntr_cmd_capture_if.slave  bus
);

  localparam int             W        = 8 * CMD_BYTES;
  localparam int             BCW      = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(CMD_BYTES - 1);
  localparam logic [DCW-1:0] DC_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_sr;
  logic [W-1:0]    r_cmd;
  logic            r_cmd_valid;
  logic [BCW-1:0]  r_byte_cnt;
  logic [DCW-1:0]  r_data_cnt;
  logic            r_abort;
  logic            r_overrun;

  logic [W-1:0]    w_shift;
  logic            w_complete;

  // After CMD_BYTES shifts the first byte has reached the end selected by MSB_FIRST
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift = (r_sr << 8) | W'(bus.data);
    end else begin : g_lsb_first
      assign w_shift = (r_sr >> 8) | {bus.data, {(W-8){1'b0}}};
    end
  endgenerate

  assign w_complete = (r_state == ST_CMD) && !bus.cs1 && (r_byte_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_byte_cnt  <= '0;
      r_data_cnt  <= '0;
      r_abort     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_abort <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!bus.cs1) begin
            r_sr       <= w_shift;
            r_data_cnt <= '0;
            r_byte_cnt <= BCW'(1);
            r_state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.cs1) begin
            r_abort    <= 1'b1;
            r_byte_cnt <= '0;
            r_sr       <= '0;
            r_state    <= ST_IDLE;
          end else if (r_byte_cnt == LAST_IDX) begin
            r_sr       <= '0;
            r_byte_cnt <= '0;
            r_state    <= ST_DATA;
          end else begin
            r_sr       <= w_shift;
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bus.cs1) begin
            r_state <= ST_IDLE;
          end else if (r_data_cnt != DC_MAX) begin
            r_data_cnt <= r_data_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A completed word only replaces cmd if the previous one is gone or leaving now
      if (w_complete) begin
        if (!r_cmd_valid || bus.cmd_ready) begin
          r_cmd       <= w_shift;
          r_cmd_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_cmd_valid && bus.cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.byte_cnt  = r_byte_cnt;
  assign bus.data_cnt  = r_data_cnt;
  assign bus.abort     = r_abort;
  assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire
